// File: rtl/uart_transmitter.sv
// uart_transmitter
//   Serialises bytes onto the UART line feeding uart_receiver on the same clock.
//   Bytes are accepted through a valid/ready port into a small circular FIFO.
//   A frame starts only while the receiver signals rts. Each frame is one low
//   start symbol, eight data symbols (MSB first) and one high stop symbol.
//   Every symbol lasts SYMBOL_EDGE_TIME clock cycles.
//
// Parameters
//   SYMBOL_EDGE_TIME  clock cycles per symbol (>= 4, must match the receiver)
//   FIFO_DEPTH        byte FIFO entries (power of 2, >= 2)
//
// Ports
//   clock          system clock, all logic on posedge
//   reset          synchronous, active-high
//   data_in        byte to transmit
//   data_in_valid  data_in is valid this cycle
//   data_in_ready  FIFO can accept a byte (push = valid && ready)
//   serial_out     registered UART line, idles high
//   rts_in         receiver is waiting and ready for a frame
//   busy           FIFO non-empty or frame in progress
//   fifo_count     current FIFO occupancy
//
// Build option
//   UART_TX_RTS_SYNC_EN  route rts_in through a 2-flop synchroniser (adds 2
//                        cycles of start latency); otherwise rts_in is used as-is.

module uart_transmitter #(
  parameter int unsigned SYMBOL_EDGE_TIME = 868,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [7:0]                    data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  output logic                          serial_out,
  input  logic                          rts_in,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0]      LAST_TICK  = 32'(SYMBOL_EDGE_TIME - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             state;
  logic [31:0]        tick_ctr;
  logic [2:0]         bit_pos;
  logic [7:0]         shift_reg;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               rts_eff;
  logic               push;
  logic               pop;
  logic               symbol_end;

`ifdef UART_TX_RTS_SYNC_EN
  logic rts_meta;
  logic rts_sync;

  always_ff @(posedge clock) begin
    if (reset) begin
      rts_meta <= 1'b0;
      rts_sync <= 1'b0;
    end else begin
      rts_meta <= rts_in;
      rts_sync <= rts_meta;
    end
  end

  assign rts_eff = rts_sync;
`else
  assign rts_eff = rts_in;
`endif

  assign data_in_ready = (fifo_count != FULL_COUNT);
  assign busy          = (state != IDLE) || (fifo_count != '0);
  assign push          = data_in_valid && data_in_ready && !reset;
  assign pop           = (state == IDLE) && (fifo_count != '0) && rts_eff;
  assign symbol_end    = (tick_ctr == LAST_TICK);

  // Storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      serial_out <= 1'b1;
      tick_ctr   <= '0;
      bit_pos    <= 3'd7;
      shift_reg  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + CNT_W'(1);
      end else if (pop && !push) begin
        fifo_count <= fifo_count - CNT_W'(1);
      end

      unique case (state)
        IDLE: begin
          serial_out <= 1'b1;
          tick_ctr   <= '0;
          if (pop) begin
            shift_reg  <= mem[rd_ptr];
            serial_out <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (symbol_end) begin
            tick_ctr   <= '0;
            serial_out <= shift_reg[7];
            bit_pos    <= 3'd7;
            state      <= DATA;
          end else begin
            tick_ctr <= tick_ctr + 32'd1;
          end
        end
        DATA: begin
          if (symbol_end) begin
            tick_ctr <= '0;
            if (bit_pos == 3'd0) begin
              serial_out <= 1'b1;
              state      <= STOP;
            end else begin
              bit_pos    <= bit_pos - 3'd1;
              serial_out <= shift_reg[bit_pos - 3'd1];
            end
          end else begin
            tick_ctr <= tick_ctr + 32'd1;
          end
        end
        STOP: begin
          if (symbol_end) begin
            tick_ctr <= '0;
            state    <= IDLE;
          end else begin
            tick_ctr <= tick_ctr + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter
//   Directed bench for uart_transmitter with 8-cycle symbols and a 4-entry FIFO.
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_uart_transmitter;

  localparam int unsigned S = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic       serial_out;
  logic       rts_in = 1'b0;
  logic       busy;
  logic [2:0] fifo_count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  uart_transmitter #(
    .SYMBOL_EDGE_TIME(S),
    .FIFO_DEPTH      (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .serial_out   (serial_out),
    .rts_in       (rts_in),
    .busy         (busy),
    .fifo_count   (fifo_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called just after the pop edge: checks all 10*S cycles of the frame and
  // leaves the bench just after the edge that returns the FSM to idle.
  task automatic check_frame(input string tag, input logic [7:0] b);
    logic exp_bit;
    for (int k = 0; k < 10 * int'(S); k++) begin
      int sym;
      sym = k / int'(S);
      if (sym == 0)      exp_bit = 1'b0;
      else if (sym == 9) exp_bit = 1'b1;
      else               exp_bit = b[8 - sym];
      check(tag, {31'b0, serial_out}, {31'b0, exp_bit});
      step();
    end
    check({tag, "_idle"}, {31'b0, serial_out}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset for two cycles, with a push attempt that must be ignored
    data_in = 8'hEE;
    data_in_valid = 1'b1;
    step();
    step();
    data_in_valid = 1'b0;
    reset = 1'b0;
    check("rst_serial", {31'b0, serial_out}, 32'd1);
    check("rst_ready",  {31'b0, data_in_ready}, 32'd1);
    check("rst_busy",   {31'b0, busy}, 32'd0);
    check("rst_count",  {29'b0, fifo_count}, 32'd0);
    step();
    check("rst_count2", {29'b0, fifo_count}, 32'd0);

    // 2: single frame 0xA5 with rts high
    rts_in = 1'b1;
    data_in = 8'hA5;
    data_in_valid = 1'b1;
    step();
    data_in_valid = 1'b0;
    check("a5_push_count", {29'b0, fifo_count}, 32'd1);
    check("a5_push_serial", {31'b0, serial_out}, 32'd1);
    step();
    check("a5_pop_count", {29'b0, fifo_count}, 32'd0);
    check("a5_pop_busy", {31'b0, busy}, 32'd1);
    check_frame("a5_frame", 8'hA5);
    check("a5_done_busy", {31'b0, busy}, 32'd0);

    // 3: rts low holds the byte; rising rts starts the frame one cycle later
    rts_in = 1'b0;
    data_in = 8'h3C;
    data_in_valid = 1'b1;
    step();
    data_in_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      check("hold_serial", {31'b0, serial_out}, 32'd1);
      check("hold_busy",   {31'b0, busy}, 32'd1);
      check("hold_count",  {29'b0, fifo_count}, 32'd1);
      step();
    end
    rts_in = 1'b1;
    step();
    check_frame("3c_frame", 8'h3C);

    // 4: fill to depth, fifth push refused, then drain in order
    rts_in = 1'b0;
    data_in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      data_in = 8'(i);
      check($sformatf("fill_ready%0d", i), {31'b0, data_in_ready}, (i <= 4) ? 32'd1 : 32'd0);
      step();
    end
    data_in_valid = 1'b0;
    check("full_count", {29'b0, fifo_count}, 32'd4);
    check("full_ready", {31'b0, data_in_ready}, 32'd0);
    rts_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("drain_count%0d", i), {29'b0, fifo_count}, 32'(4 - i));
      check_frame($sformatf("drain%0d", i), 8'(i));
    end
    check("drain_busy", {31'b0, busy}, 32'd0);
    check("drain_ready", {31'b0, data_in_ready}, 32'd1);

    // 5: reset in the middle of the bit_pos=4 symbol aborts and flushes
    data_in = 8'hC3;
    data_in_valid = 1'b1;
    step();
    data_in = 8'h99;
    step();
    data_in_valid = 1'b0;
    check("mid_count", {29'b0, fifo_count}, 32'd1);
    for (int i = 0; i < 4 * int'(S) + 2; i++) step();
    check("mid_bit4", {31'b0, serial_out}, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_serial", {31'b0, serial_out}, 32'd1);
    check("abort_count",  {29'b0, fifo_count}, 32'd0);
    check("abort_busy",   {31'b0, busy}, 32'd0);
    for (int i = 0; i < 3 * int'(S); i++) begin
      check("abort_quiet", {31'b0, serial_out}, 32'd1);
      step();
    end
    data_in = 8'h5A;
    data_in_valid = 1'b1;
    step();
    data_in_valid = 1'b0;
    step();
    check_frame("5a_frame", 8'h5A);

    // 6: start latency after rts rises with one byte queued
    rts_in = 1'b0;
    data_in = 8'h81;
    data_in_valid = 1'b1;
    step();
    data_in_valid = 1'b0;
    step();
    step();
    rts_in = 1'b1;
`ifdef UART_TX_RTS_SYNC_EN
    step();
    check("sync_lat1", {31'b0, serial_out}, 32'd1);
    step();
    check("sync_lat2", {31'b0, serial_out}, 32'd1);
`endif
    step();
    check_frame("81_frame", 8'h81);
    check("final_busy", {31'b0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
